// File: rtl/pipelined_butterfly.sv
// rtl/pipelined_butterfly.sv - three-stage radix-2 butterfly with valid/ready flow control
//
// Computes y1 = x1 + x2 and y2 = (x1 - x2) * W, one operation per cycle, latency 3.
//   S1: A = x1 + x2, B = x1 - x2 (DATA_W+1 bits, exact)
//   S2: P = B * W (full precision, DATA_W+TW_W+2 bits)
//   S3: y1 = round(A >> s), y2 = round(P >> (TW_W-1+s)), narrowed to DATA_W
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   in_valid / in_ready         operand handshake (in_ready = pipeline advance)
//   x1_*, x2_*, tw_*, scale     operands, twiddle (Q1.TW_W-1), per-op divide-by-2
//   out_valid / out_ready       result handshake
//   y1_*, y2_*                  results (stage-3 registers)
//   ovf, ovf_clr                sticky overflow flag and its synchronous clear
//
// Build option: PIPELINED_BUTTERFLY_SAT_EN defined -> out-of-range results clamp;
// undefined -> they wrap. ovf sets in both builds.

module pipelined_butterfly #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1_re,
  input  logic signed [DATA_W-1:0] x1_im,
  input  logic signed [DATA_W-1:0] x2_re,
  input  logic signed [DATA_W-1:0] x2_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic signed [DATA_W-1:0] y2_re,
  output logic signed [DATA_W-1:0] y2_im,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = DATA_W + 1;
  localparam int MW = DATA_W + TW_W + 1;
  localparam int PW = DATA_W + TW_W + 2;
  localparam int RW = PW + 1;  // one spare bit so the rounding add cannot wrap

  logic advance;

  // stage 1
  logic                   v1_q, s1_q;
  logic signed [AW-1:0]   a1_re_q, a1_im_q, b1_re_q, b1_im_q;
  logic signed [AW-1:0]   a1_re_d, a1_im_d, b1_re_d, b1_im_d;
  logic signed [TW_W-1:0] tw1_re_q, tw1_im_q;

  // stage 2
  logic                   v2_q, s2_q;
  logic signed [AW-1:0]   a2_re_q, a2_im_q;
  logic signed [MW-1:0]   m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0]   p2_re_q, p2_im_q, p2_re_d, p2_im_d;

  // stage 3 (outputs); narrowed results carry the overflow flag in the top bit
  logic                   out_valid_q, ovf_q, ovf_d, ovf_any;
  logic [DATA_W-1:0]      y1_re_q, y1_im_q, y2_re_q, y2_im_q;
  logic [DATA_W:0]        y1_re_d, y1_im_d, y2_re_d, y2_im_d;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [RW-1:0] v,
                                                       input int sh);
    logic signed [RW-1:0] half;
    if (sh == 0) return v;
    half = RW'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  // Returns {overflow, narrowed value}. In range means every bit from the MSB down
  // to bit DATA_W-1 agrees with the sign.
  function automatic logic [DATA_W:0] narrow(input logic signed [RW-1:0] v);
    logic [RW-DATA_W:0] top;
    logic               o;
    logic [DATA_W-1:0]  r;
    top = v[RW-1:DATA_W-1];
    o   = !((&top) || !(|top));
    r   = v[DATA_W-1:0];
`ifdef PIPELINED_BUTTERFLY_SAT_EN
    if (o) r = v[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return {o, r};
  endfunction

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign y1_re     = y1_re_q;
  assign y1_im     = y1_im_q;
  assign y2_re     = y2_re_q;
  assign y2_im     = y2_im_q;

  always_comb begin
    a1_re_d = AW'(x1_re) + AW'(x2_re);
    a1_im_d = AW'(x1_im) + AW'(x2_im);
    b1_re_d = AW'(x1_re) - AW'(x2_re);
    b1_im_d = AW'(x1_im) - AW'(x2_im);

    m_rr    = MW'(b1_re_q) * MW'(tw1_re_q);
    m_ii    = MW'(b1_im_q) * MW'(tw1_im_q);
    m_ri    = MW'(b1_re_q) * MW'(tw1_im_q);
    m_ir    = MW'(b1_im_q) * MW'(tw1_re_q);
    p2_re_d = PW'(m_rr) - PW'(m_ii);
    p2_im_d = PW'(m_ri) + PW'(m_ir);

    y1_re_d = narrow(round_shift(RW'(a2_re_q), s2_q ? 1 : 0));
    y1_im_d = narrow(round_shift(RW'(a2_im_q), s2_q ? 1 : 0));
    y2_re_d = narrow(round_shift(RW'(p2_re_q), TW_W - 1 + (s2_q ? 1 : 0)));
    y2_im_d = narrow(round_shift(RW'(p2_im_q), TW_W - 1 + (s2_q ? 1 : 0)));
    ovf_any = y1_re_d[DATA_W] | y1_im_d[DATA_W] | y2_re_d[DATA_W] | y2_im_d[DATA_W];

    // a same-cycle overflow beats the clear
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (advance && v2_q && ovf_any) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      a1_re_q     <= '0;
      a1_im_q     <= '0;
      b1_re_q     <= '0;
      b1_im_q     <= '0;
      tw1_re_q    <= '0;
      tw1_im_q    <= '0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      a2_re_q     <= '0;
      a2_im_q     <= '0;
      p2_re_q     <= '0;
      p2_im_q     <= '0;
      out_valid_q <= 1'b0;
      y1_re_q     <= '0;
      y1_im_q     <= '0;
      y2_re_q     <= '0;
      y2_im_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      // the whole pipeline moves together, so bubbles are simply overwritten
      if (advance) begin
        v1_q        <= in_valid;
        s1_q        <= scale;
        a1_re_q     <= a1_re_d;
        a1_im_q     <= a1_im_d;
        b1_re_q     <= b1_re_d;
        b1_im_q     <= b1_im_d;
        tw1_re_q    <= tw_re;
        tw1_im_q    <= tw_im;
        v2_q        <= v1_q;
        s2_q        <= s1_q;
        a2_re_q     <= a1_re_q;
        a2_im_q     <= a1_im_q;
        p2_re_q     <= p2_re_d;
        p2_im_q     <= p2_im_d;
        out_valid_q <= v2_q;
        if (v2_q) begin
          y1_re_q <= y1_re_d[DATA_W-1:0];
          y1_im_q <= y1_im_d[DATA_W-1:0];
          y2_re_q <= y2_re_d[DATA_W-1:0];
          y2_im_q <= y2_im_d[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_butterfly.sv
// tb/tb_pipelined_butterfly.sv - scoreboard bench for pipelined_butterfly (DATA_W=16, TW_W=16)

module tb_pipelined_butterfly;

  typedef struct {
    logic signed [15:0] x1r, x1i, x2r, x2i, twr, twi;
    logic               s;
  } op_t;

  typedef struct {
    logic signed [15:0] y1r, y1i, y2r, y2i;
    logic               o;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               n_rst, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] x1_re, x1_im, x2_re, x2_im, tw_re, tw_im;
  logic signed [15:0] y1_re, y1_im, y2_re, y2_im;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipelined_butterfly #(.DATA_W(16), .TW_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
    .tw_re(tw_re), .tw_im(tw_im), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .y1_re(y1_re), .y1_im(y1_im), .y2_re(y2_re), .y2_im(y2_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // ---------------- reference model ----------------
  function automatic longint rnd(input longint v, input int sh);
    longint d, n;
    if (sh == 0) return v;
    d = longint'(1) << sh;
    n = v + d / 2;
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic logic signed [15:0] nar(input longint v, inout logic o);
    logic [63:0] b;
    b = v;
    if (v > 32767 || v < -32768) begin
      o = 1'b1;
`ifdef PIPELINED_BUTTERFLY_SAT_EN
      return (v > 0) ? 16'sh7FFF : 16'sh8000;
`endif
    end
    return b[15:0];
  endfunction

  function automatic res_t model(input op_t p);
    res_t   r;
    logic   o;
    longint ar, ai, br, bi, pr, pi;
    int     s;
    ar = longint'(p.x1r) + longint'(p.x2r);
    ai = longint'(p.x1i) + longint'(p.x2i);
    br = longint'(p.x1r) - longint'(p.x2r);
    bi = longint'(p.x1i) - longint'(p.x2i);
    pr = br * longint'(p.twr) - bi * longint'(p.twi);
    pi = br * longint'(p.twi) + bi * longint'(p.twr);
    s  = p.s ? 1 : 0;
    o  = 1'b0;
    r.y1r = nar(rnd(ar, s), o);
    r.y1i = nar(rnd(ai, s), o);
    r.y2r = nar(rnd(pr, 15 + s), o);
    r.y2i = nar(rnd(pi, 15 + s), o);
    r.o   = o;
    return r;
  endfunction

  function automatic logic [63:0] pack(input res_t r);
    return {r.y1r, r.y1i, r.y2r, r.y2i};
  endfunction

  function automatic op_t mk(input int a, input int b, input int c, input int d,
                             input int e, input int f, input logic s);
    op_t p;
    p.x1r = 16'(a); p.x1i = 16'(b); p.x2r = 16'(c); p.x2i = 16'(d);
    p.twr = 16'(e); p.twi = 16'(f); p.s = s;
    return p;
  endfunction

  function automatic op_t rand_op();
    op_t p;
    int  k;
    if ($urandom_range(1) == 0) begin
      p.x1r = 16'(int'($urandom_range(4000)) - 2000);
      p.x1i = 16'(int'($urandom_range(4000)) - 2000);
      p.x2r = 16'(int'($urandom_range(4000)) - 2000);
      p.x2i = 16'(int'($urandom_range(4000)) - 2000);
    end else begin
      p.x1r = 16'($urandom); p.x1i = 16'($urandom);
      p.x2r = 16'($urandom); p.x2i = 16'($urandom);
    end
    k = int'($urandom_range(3));
    p.twr = (k == 0) ? 16'sh7FFF : (k == 1) ? 16'sh8000 : (k == 2) ? 16'sh0000 : 16'($urandom);
    p.twi = (k == 1) ? 16'sh0000 : (k == 2) ? 16'sh8000 : 16'($urandom);
    p.s   = 1'($urandom_range(1));
    return p;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input op_t p);
    x1_re = p.x1r; x1_im = p.x1i; x2_re = p.x2r; x2_im = p.x2i;
    tw_re = p.twr; tw_im = p.twi; scale = p.s;
  endtask

  // Transfers one operation into an empty pipeline and waits for its result.
  // lat counts rising edges from the transfer edge (inclusive) to out_valid.
  task automatic send_and_wait(input op_t p, output int lat);
    drive(p);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sb.push_back(model(p));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== 64'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {y1_re, y1_im, y2_re, y2_im}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    n_rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_latency();
    int   lat;
    res_t e;
    send_and_wait(mk(1000, 0, 200, 0, 32767, 0, 1'b0), lat);
    e = sb.pop_front();
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency got %0d exp 3", lat); end
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL lat_result got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    checks++; if (y1_re !== 16'sd1200 || y2_re !== 16'sd800) begin errors++; $display("FAIL lat_literal got %0d/%0d exp 1200/800", y1_re, y2_re); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL lat_ovf got %b exp 0", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int   lat;
    res_t e;
    send_and_wait(mk(1000, 0, 200, 0, 0, -32768, 1'b0), lat);
    e = sb.pop_front();
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL minus_j got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    checks++; if (y2_re !== 16'sd0 || y2_im !== -16'sd800) begin errors++; $display("FAIL minus_j_literal got %0d/%0d exp 0/-800", y2_re, y2_im); end
    @(posedge clk); #1;
    send_and_wait(mk(1001, 0, 200, 0, 32767, 0, 1'b1), lat);
    e = sb.pop_front();
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL scaled got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    checks++; if (y1_re !== 16'sd601) begin errors++; $display("FAIL scaled_y1 got %0d exp 601", y1_re); end
    @(posedge clk); #1;
    send_and_wait(mk(-1000, 77, 3000, -5, -32768, 0, 1'b0), lat);
    e = sb.pop_front();
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL tw_neg_one got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    int          lat;
    res_t        e;
    logic [15:0] exp_y1;
`ifdef PIPELINED_BUTTERFLY_SAT_EN
    exp_y1 = 16'd32767;
`else
    exp_y1 = 16'hEA60;  // -5536
`endif
    send_and_wait(mk(30000, 0, 30000, 0, 32767, 0, 1'b0), lat);
    e = sb.pop_front();
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL ovf_result got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    checks++; if (y1_re !== exp_y1) begin errors++; $display("FAIL ovf_y1 got %0d exp %0d", y1_re, $signed(exp_y1)); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    send_and_wait(mk(30000, 0, 30000, 0, 32767, 0, 1'b1), lat);
    e = sb.pop_front();
    checks++; if (y1_re !== 16'sd30000 || {y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL ovf_scaled got %h exp %h", {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_scaled_flag got %b exp 0", ovf); end
    @(posedge clk); #1;
    // clear held through an overflowing load: the set must win on that edge
    ovf_clr = 1'b1;
    send_and_wait(mk(-30000, 0, -30000, 0, 32767, 0, 1'b0), lat);
    void'(sb.pop_front());
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf); end
    @(posedge clk); #1;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_after got %b exp 0", ovf); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    op_t         ops[6];
    res_t        e;
    int          sent = 0, got = 0, c = 0;
    logic        stalled_prev = 1'b0;
    logic        saw_drop = 1'b0;
    logic        dup = 1'b0;
    logic [63:0] snap = '0;
    ops[0] = mk(100, -100, 50, 25, 32767, 0, 1'b0);
    ops[1] = mk(-2000, 300, 700, -900, 0, -32768, 1'b0);
    ops[2] = mk(12345, -54, -321, 999, -32768, 0, 1'b1);
    ops[3] = mk(7, 8, 9, 10, 23170, -23170, 1'b0);
    ops[4] = mk(-32768, 32767, 32767, -32768, -32768, -32768, 1'b1);
    ops[5] = mk(555, -555, -1, 1, 16384, 16384, 1'b0);
    while (got < 6 && c < 60) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (sent < 6);
      if (sent < 6) drive(ops[sent]);
      @(negedge clk);
      checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b exp %b", c, in_ready, !out_valid || out_ready); end
      if (!in_ready) saw_drop = 1'b1;
      if (stalled_prev) begin
        checks++; if ({y1_re, y1_im, y2_re, y2_im} !== snap) begin errors++; $display("FAIL b2b_stable cycle %0d got %h exp %h", c, {y1_re, y1_im, y2_re, y2_im}, snap); end
      end
      stalled_prev = out_valid && !out_ready;
      snap = {y1_re, y1_im, y2_re, y2_im};
      if (in_valid && in_ready) begin
        sb.push_back(model(ops[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        checks++; if (snap !== pack(e)) begin errors++; $display("FAIL b2b_result %0d got %h exp %h", got, snap, pack(e)); end
        got++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got); end
    checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL b2b_backpressure got %b exp 1", saw_drop); end
    repeat (4) begin
      @(negedge clk);
      if (out_valid) dup = 1'b1;
    end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL b2b_extra_result got %b exp 0", dup); end
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    op_t  cur;
    res_t e;
    int   sent = 0, got = 0, c = 0;
    logic model_ovf = 1'b0;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    cur = rand_op();
    while (got < 40 && c < 800) begin
      in_valid  = (sent < 40) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      drive(cur);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(cur));
        sent++;
        cur = rand_op();
      end
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        model_ovf = model_ovf | e.o;
        checks++; if ({y1_re, y1_im, y2_re, y2_im} !== pack(e)) begin errors++; $display("FAIL rand_result %0d got %h exp %h", got, {y1_re, y1_im, y2_re, y2_im}, pack(e)); end
        checks++; if (ovf !== model_ovf) begin errors++; $display("FAIL rand_ovf %0d got %b exp %b", got, ovf, model_ovf); end
        got++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 40) begin errors++; $display("FAIL rand_count got %0d exp 40", got); end
    sb.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_flight();
    int   lat;
    logic seen = 1'b0;
    send_and_wait(mk(30000, 0, 30000, 0, 32767, 0, 1'b0), lat);
    void'(sb.pop_front());
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL flight_pre_ovf got %b exp 1", ovf); end
    drive(mk(11, 22, 33, 44, 32767, 0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(mk(-5, 6, -7, 8, 0, -32768, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_out_valid got %b exp 0", out_valid); end
    checks++; if ({y1_re, y1_im, y2_re, y2_im} !== 64'd0) begin errors++; $display("FAIL flight_outputs got %h exp 0", {y1_re, y1_im, y2_re, y2_im}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL flight_ovf got %b exp 0", ovf); end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flight_ghost_result got %b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_ovf();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
